glyph_matcher: RTL and testbench

//   Recognises a captured 16x16 monochrome bitmap as one of NUM_GLYPHS stored digit glyphs.
//   It reads the glyph ROM set one row per cycle, once per digit, and accumulates a Hamming

---
 rtl/glyph_matcher.sv | 168 ++++++++++++++++
 tb/tb_glyph_matcher.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_matcher.sv
// Scans a 16x16 capture buffer against NUM_GLYPHS glyph ROM templates, one row per
// cycle, and reports the closest digit, its Hamming distance and a threshold match.
module glyph_matcher #(
    parameter int NUM_GLYPHS   = 10,
    parameter int MATCH_THRESH = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_row,
    input  logic [15:0] wr_data,
    input  logic        start,
    output logic [3:0]  rom_sel,
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_row,
    output logic        busy,
    output logic        done,
    output logic [3:0]  best_digit,
    output logic [8:0]  best_dist,
    output logic        match
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_DIGIT = 4'(NUM_GLYPHS - 1);
    localparam logic [8:0] THRESH     = 9'(MATCH_THRESH);

    state_t      state_r;
    state_t      state_s;
    logic [15:0] cap_r [16];
    logic [3:0]  digit_r;
    logic [3:0]  row_r;
    logic [8:0]  acc_r;
    logic [8:0]  cand_dist_r;
    logic [3:0]  cand_digit_r;
    logic [4:0]  pc_s;
    logic [8:0]  tot_s;
    logic        take_s;
    logic        last_row_s;
    logic        scan_end_s;
    logic [8:0]  sel_dist_s;
    logic [3:0]  sel_digit_s;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Row distance, running total and best-so-far selection for the current cycle
    always_comb begin
        pc_s        = popcount16(cap_r[row_r] ^ rom_row);
        last_row_s  = (row_r == 4'd15);
        scan_end_s  = (state_r == ST_SCAN) && last_row_s && (digit_r == LAST_DIGIT);
        if (row_r == 4'd0) begin
            tot_s = {4'd0, pc_s};
        end else begin
            tot_s = acc_r + {4'd0, pc_s};
        end
        // strict less-than: on a tie the lower digit index is kept
        take_s = (digit_r == 4'd0) || (tot_s < cand_dist_r);
        if (take_s) begin
            sel_dist_s  = tot_s;
            sel_digit_s = digit_r;
        end else begin
            sel_dist_s  = cand_dist_r;
            sel_digit_s = cand_digit_r;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (scan_end_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy     = (state_r != ST_IDLE);
        done     = (state_r == ST_DONE);
        rom_sel  = digit_r;
        rom_addr = row_r;
    end

    // Capture buffer: writable only while idle, frozen during a scan
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                cap_r[i] <= 16'd0;
            end
        end else if ((state_r == ST_IDLE) && wr_en) begin
            cap_r[wr_row] <= wr_data;
        end
    end

    // Scan counters, accumulator and candidate registers
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_r      <= 4'd0;
            row_r        <= 4'd0;
            acc_r        <= 9'd0;
            cand_dist_r  <= 9'd0;
            cand_digit_r <= 4'd0;
        end else if (state_r == ST_SCAN) begin
            row_r <= row_r + 4'd1;
            acc_r <= tot_s;
            if (last_row_s) begin
                cand_dist_r  <= sel_dist_s;
                cand_digit_r <= sel_digit_s;
                if (digit_r == LAST_DIGIT) begin
                    digit_r <= 4'd0;
                end else begin
                    digit_r <= digit_r + 4'd1;
                end
            end
        end else begin
            digit_r <= 4'd0;
            row_r   <= 4'd0;
        end
    end

    // Result registers, loaded only on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            best_digit <= 4'd0;
            best_dist  <= 9'd0;
            match      <= 1'b0;
        end else if (scan_end_s) begin
            best_digit <= sel_digit_s;
            best_dist  <= sel_dist_s;
            match      <= (sel_dist_s <= THRESH);
        end
    end

endmodule

// File: tb/tb_glyph_matcher.sv
// Self-checking bench for glyph_matcher: table-driven scenarios, hand sequences for
// reset/ignored-input corners, and randomized scans checked against a reference model.
module tb_glyph_matcher;

    logic        clk = 1'b0;
    logic        rst, wr_en, start;
    logic [3:0]  wr_row;
    logic [15:0] wr_data;
    logic [3:0]  rom_sel, rom_addr;
    logic [15:0] rom_row;
    logic        busy, done, match;
    logic [3:0]  best_digit;
    logic [8:0]  best_dist;

    logic        start1;
    logic [3:0]  rom_sel1, rom_addr1;
    logic [15:0] rom_row1;
    logic        busy1, done1, match1;
    logic [3:0]  best_digit1;
    logic [8:0]  best_dist1;

    logic [15:0] rom_mem [16][16];
    logic [15:0] img [16];
    logic [15:0] tie_pat [16];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rom_row  = rom_mem[rom_sel][rom_addr];
    assign rom_row1 = rom_mem[rom_sel1][rom_addr1];

    glyph_matcher #(.NUM_GLYPHS(10), .MATCH_THRESH(40)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .start(start), .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_row(rom_row),
        .busy(busy), .done(done), .best_digit(best_digit), .best_dist(best_dist),
        .match(match)
    );

    glyph_matcher #(.NUM_GLYPHS(1), .MATCH_THRESH(40)) dut1 (
        .clk(clk), .rst(rst), .wr_en(1'b0), .wr_row(4'd0), .wr_data(16'd0),
        .start(start1), .rom_sel(rom_sel1), .rom_addr(rom_addr1), .rom_row(rom_row1),
        .busy(busy1), .done(done1), .best_digit(best_digit1), .best_dist(best_dist1),
        .match(match1)
    );

    typedef struct {
        int         rom_kind;   // 0 seven-segment digits, 1 tie stub, 2 ink-count stub
        int         buf_kind;   // 0 exact 3, 1 three with 5 flips, 2 all ones, 3 tie pattern, 4 zero
        logic [3:0] exp_digit;
        logic [8:0] exp_dist;
        logic       exp_match;
        string      name;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Segment a=0 b=1 c=2 d=3 e=4 f=5 g=6 covering pixel (r,c), or -1
    function automatic int seg_at(input int r, input int c);
        if (r >= 1 && r <= 2 && c >= 4 && c <= 11) return 0;
        if (r >= 3 && r <= 6 && c >= 12 && c <= 13) return 1;
        if (r >= 9 && r <= 12 && c >= 12 && c <= 13) return 2;
        if (r >= 13 && r <= 14 && c >= 4 && c <= 11) return 3;
        if (r >= 9 && r <= 12 && c >= 2 && c <= 3) return 4;
        if (r >= 3 && r <= 6 && c >= 2 && c <= 3) return 5;
        if (r >= 7 && r <= 8 && c >= 4 && c <= 11) return 6;
        return -1;
    endfunction

    function automatic logic [6:0] seg_mask(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [15:0] real_row(input int d, input int r);
        logic [15:0] v;
        logic [6:0]  m;
        int          s;
        v = 16'd0;
        m = seg_mask(d);
        for (int c = 0; c < 16; c++) begin
            s = seg_at(r, c);
            if (s >= 0) v[c] = m[s];
        end
        return v;
    endfunction

    task automatic set_rom(input int kind);
        for (int d = 0; d < 16; d++) begin
            for (int r = 0; r < 16; r++) begin
                case (kind)
                    0: rom_mem[d][r] = real_row(d, r);
                    1: rom_mem[d][r] = (d == 4 || d == 7) ? tie_pat[r] : ~tie_pat[r];
                    default: begin
                        rom_mem[d][r] = 16'd0;
                        for (int c = 0; c < 16; c++) begin
                            rom_mem[d][r][c] = ((r * 16 + c) < (20 + d));
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic set_img(input int kind);
        for (int r = 0; r < 16; r++) begin
            case (kind)
                0: img[r] = real_row(3, r);
                1: img[r] = (r == 0) ? (real_row(3, 0) ^ 16'h001F) : real_row(3, r);
                2: img[r] = 16'hFFFF;
                3: img[r] = tie_pat[r];
                default: img[r] = 16'd0;
            endcase
        end
    endtask

    // Reference: per-digit Hamming distance over the whole bitmap, first minimum wins
    task automatic model(input int ng, output logic [3:0] dg, output logic [8:0] ds,
                         output logic m);
        int best, bestd, sum;
        best = 0;
        bestd = 0;
        for (int d = 0; d < ng; d++) begin
            sum = 0;
            for (int r = 0; r < 16; r++) sum += $countones(img[r] ^ rom_mem[d][r]);
            if (d == 0 || sum < best) begin
                best = sum;
                bestd = d;
            end
        end
        dg = 4'(bestd);
        ds = 9'(best);
        m  = (best <= 40);
    endtask

    // Optionally load img (row 15 written in the same cycle as start), else start alone
    task automatic load_start(input bit load);
        if (load) begin
            for (int r = 0; r < 16; r++) begin
                wr_en   = 1'b1;
                wr_row  = 4'(r);
                wr_data = img[r];
                start   = (r == 15);
                @(posedge clk); #1;
            end
        end else begin
            start = 1'b1;
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    // Runs from scan cycle 1 to done, checking timing and status; poke>0 injects start+write
    task automatic wait_done(input string name, input int poke, input logic [3:0] exp_dg,
                             input logic [8:0] exp_ds, input logic exp_m);
        int lat, busy_bad, chg;
        logic [3:0] p_dg;
        logic [8:0] p_ds;
        logic       p_m;
        p_dg = best_digit;
        p_ds = best_dist;
        p_m  = match;
        lat = 1;
        busy_bad = 0;
        chg = 0;
        while (!done && lat < 400) begin
            if (!busy) busy_bad++;
            if (best_digit !== p_dg || best_dist !== p_ds || match !== p_m) chg++;
            if (lat == poke) begin
                start = 1'b1; wr_en = 1'b1; wr_row = 4'd0; wr_data = 16'hFFFF;
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        wr_en = 1'b0;
        chg += (busy ? 0 : 1);
        chk({name, "_latency"}, lat, 161);
        chk({name, "_busy_gaps"}, busy_bad + chg, 0);
        chk({name, "_digit"}, best_digit, exp_dg);
        chk({name, "_dist"}, best_dist, exp_ds);
        chk({name, "_match"}, match, exp_m);
        @(posedge clk); #1;
        chk({name, "_idle_after"}, {30'd0, busy, done}, 0);
    endtask

    initial begin
        logic [3:0] mdg;
        logic [8:0] mds;
        logic       mm;
        int         k, nflip, lat, seen;

        rst = 1'b1; wr_en = 1'b0; start = 1'b0; start1 = 1'b0;
        wr_row = 4'd0; wr_data = 16'd0;
        for (int r = 0; r < 16; r++) tie_pat[r] = 16'($urandom);
        set_rom(0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_outputs", {busy, done, match, best_digit, best_dist, rom_sel, rom_addr}, 0);

        vecs[0] = '{0, 0, 4'd3, 9'd0,   1'b1, "exact3"};
        vecs[1] = '{0, 1, 4'd3, 9'd5,   1'b1, "flip5"};
        vecs[2] = '{0, 2, 4'd8, 9'd176, 1'b0, "all_ones"};
        vecs[3] = '{1, 3, 4'd4, 9'd0,   1'b1, "tie_4_7"};
        vecs[4] = '{2, 4, 4'd0, 9'd20,  1'b1, "ink_stub"};
        for (int i = 0; i < 5; i++) begin
            set_rom(vecs[i].rom_kind);
            set_img(vecs[i].buf_kind);
            load_start(1'b1);
            wait_done(vecs[i].name, 0, vecs[i].exp_digit, vecs[i].exp_dist, vecs[i].exp_match);
        end

        // Single-glyph instance: done in cycle 17 (ROM still the ink stub, its buffer is zero)
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 1;
        while (!done1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ng1_latency", lat, 17);
        chk("ng1_result", {best_digit1, best_dist1, match1}, {4'd0, 9'd20, 1'b1});

        // Reset at scan cycle 80 aborts the scan and clears the buffer
        set_rom(0);
        set_img(0);
        load_start(1'b1);
        repeat (79) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midscan_rst_outputs",
            {busy, done, match, best_digit, best_dist, rom_sel, rom_addr}, 0);
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        chk("midscan_rst_no_done", seen, 0);
        set_rom(2);
        set_img(4);
        model(10, mdg, mds, mm);
        load_start(1'b0);
        wait_done("buf_cleared", 0, mdg, mds, mm);
        set_rom(0);
        set_img(0);
        load_start(1'b1);
        wait_done("after_rst", 0, 4'd3, 9'd0, 1'b1);

        // Start and a row-0 write during the scan are both dropped
        load_start(1'b1);
        wait_done("poke_scan", 50, 4'd3, 9'd0, 1'b1);
        load_start(1'b0);
        wait_done("row0_kept", 0, 4'd3, 9'd0, 1'b1);

        // Randomized templates and noisy bitmaps against the reference model
        for (int t = 0; t < 8; t++) begin
            for (int d = 0; d < 16; d++)
                for (int r = 0; r < 16; r++) rom_mem[d][r] = 16'($urandom);
            k = $urandom_range(0, 9);
            for (int r = 0; r < 16; r++) img[r] = rom_mem[k][r];
            nflip = $urandom_range(0, 60);
            for (int f = 0; f < nflip; f++) begin
                img[$urandom_range(0, 15)][$urandom_range(0, 15)] ^= 1'b1;
            end
            model(10, mdg, mds, mm);
            load_start(1'b1);
            wait_done($sformatf("rand%0d", t), 0, mdg, mds, mm);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
